// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared loader constants, state codes and bit-reverse helper
package fft_pkg;

    localparam int N_POINTS = 2048;
    localparam int IDX_W    = 11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FILL  = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_START = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_loader_addr_gen.sv
// rtl/fft_loader_addr_gen.sv - frame sample counter and bank/address decode
// FFT_LOAD_BITREV_EN selects bit-reversed write ordering.
module fft_load_addr_gen
    import fft_pkg::*;
#(
    parameter int AW    = 9,
    parameter int NBANK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    output logic             idx_last,
    output logic [AW-1:0]    addr,
    output logic [NBANK-1:0] we_onehot
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] widx;

    assign idx_last = (idx_q == IDX_LAST);

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
`ifdef FFT_LOAD_BITREV_EN
        widx = bitrev(idx_q);
`else
        widx = idx_q;
`endif
    end

    assign addr      = widx[AW-1:0];
    assign we_onehot = NBANK'(1) << widx[IDX_W-1:AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/fft_loader.sv
// rtl/fft_loader.sv - streams one ADC frame into fft_top input banks and sequences START/DONE
// Optional FFT_LOAD_BITREV_EN (in fft_load_addr_gen) writes in bit-reversed order.
module fft_loader
    import fft_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 9,
    parameter int NBANK     = 4,
    parameter int START_DLY = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iARM,
    input  logic [DW-1:0]    iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [DW-1:0]    oDATA,
    output logic [AW-1:0]    oADDR,
    output logic [NBANK-1:0] oWE,
    output logic             oSTART,
    input  logic             iRDY,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oDROP
);

    localparam int GW = $clog2(START_DLY + 1);

    state_t           state_q, state_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [DW-1:0]    data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NBANK-1:0] we_q, we_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic             accept;
    logic             idx_last;
    logic [AW-1:0]    gen_addr;
    logic [NBANK-1:0] gen_we;

    assign oREADY = (state_q == ST_FILL);
    assign oBUSY  = (state_q != ST_IDLE);
    assign oSTART = (state_q == ST_START);
    assign oDATA  = data_q;
    assign oADDR  = addr_q;
    assign oWE    = we_q;
    assign oDONE  = done_q;
    assign oDROP  = drop_q;
    assign accept = iVALID & oREADY;

    fft_load_addr_gen #(
        .AW    (AW),
        .NBANK (NBANK)
    ) u_addr_gen (
        .clk       (iCLK),
        .rst_n     (iRESET),
        .accept    (accept),
        .idx_last  (idx_last),
        .addr      (gen_addr),
        .we_onehot (gen_we)
    );

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        rdy_d   = iRDY;
        case (state_q)
            ST_IDLE: if (iARM) state_d = ST_FILL;
            ST_FILL: begin
                if (accept && idx_last) begin
                    state_d = ST_GAP;
                    gcnt_d  = '0;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(START_DLY - 1)) state_d = ST_START;
                else                              gcnt_d  = gcnt_q + 1'b1;
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // Only a fresh rising edge counts; a level left high by the previous frame must not.
                if (iRDY && !rdy_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d = accept ? iDATA : data_q;
        addr_d = accept ? gen_addr : addr_q;
        we_d   = accept ? gen_we : '0;
        drop_d = iVALID & ~oREADY;
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            gcnt_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fft_loader.sv
// tb/tb_fft_loader.sv - randomized frame-level bench for fft_loader against a timeline model
module tb_fft_loader;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic [15:0] din;
    logic        valid;
    logic        ready;
    logic [15:0] dout;
    logic [8:0]  addr;
    logic [3:0]  we;
    logic        start;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        drop;

    int vectors    = 0;
    int miscompares = 0;

    int m_phase  = 0;
    int m_cnt    = 0;
    int t_last   = 0;
    int cyc      = 0;
    int prev_rdy = 0;

    fft_loader dut (
        .iCLK   (clk),
        .iRESET (rst_n),
        .iARM   (arm),
        .iDATA  (din),
        .iVALID (valid),
        .oREADY (ready),
        .oDATA  (dout),
        .oADDR  (addr),
        .oWE    (we),
        .oSTART (start),
        .iRDY   (rdy),
        .oBUSY  (busy),
        .oDONE  (done),
        .oDROP  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int wmap(input int c);
        int r;
        r = c;
`ifdef FFT_LOAD_BITREV_EN
        r = 0;
        for (int b = 0; b < 11; b++) begin
            if (((c >> b) & 1) != 0) r = r | (1 << (10 - b));
        end
`endif
        return r;
    endfunction

    task automatic step(input logic v, input logic [15:0] d, input logic a, input logic r);
        int e_we, e_addr, e_data, e_drop, e_start, e_done, w;
        valid = v; din = d; arm = a; rdy = r;
        @(posedge clk);
        cyc++;
        e_we = 0; e_addr = 0; e_data = 0; e_drop = 0; e_start = 0; e_done = 0;
        case (m_phase)
            0: begin
                e_drop = int'(v);
                if (a) m_phase = 1;
            end
            1: begin
                if (v) begin
                    w      = wmap(m_cnt);
                    e_we   = 1 << (w / 512);
                    e_addr = w % 512;
                    e_data = int'(d);
                    if (m_cnt == 2047) begin
                        m_phase = 2;
                        t_last  = cyc;
                    end
                    m_cnt = (m_cnt + 1) % 2048;
                end
            end
            default: begin
                e_drop = int'(v);
                if (cyc == t_last + 2) e_start = 1;
                if (cyc >= t_last + 4 && r && prev_rdy == 0) begin
                    e_done  = 1;
                    m_phase = 0;
                end
            end
        endcase
        prev_rdy = int'(r);
        #1;
        check("we", int'(we), e_we);
        check("ready", int'(ready), int'(m_phase == 1));
        check("busy", int'(busy), int'(m_phase != 0));
        check("start", int'(start), e_start);
        check("done", int'(done), e_done);
        check("drop", int'(drop), e_drop);
        if (e_we != 0) begin
            check("addr", int'(addr), e_addr);
            check("data", int'(dout), e_data);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, int'(we), 0);
        check({tag, "_start"}, int'(start), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_drop"}, int'(drop), 0);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_data"}, int'(dout), 0);
    endtask

    task automatic do_reset(input string tag);
        valid = 1'b0; arm = 1'b0; rdy = 1'b0; din = '0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        m_phase = 0; m_cnt = 0; prev_rdy = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill(input int vpct, input bit idx_data, input bit arm_noise, input bit rdy_hi,
                        input int stop_at);
        int n;
        logic v;
        logic [15:0] d;
        n = 0;
        while (m_phase == 1 && m_cnt != stop_at && n < 20000) begin
            v = ($urandom_range(99) < vpct);
            d = idx_data ? 16'(m_cnt) : 16'($urandom);
            step(v, d, arm_noise && ($urandom_range(49) == 0), rdy_hi);
            n++;
        end
        check("fill_bound", int'(n < 20000), 1);
    endtask

    task automatic finish_frame(input bit rdy_hi, input bit post_valid);
        int j;
        logic r;
        j = 0;
        while (m_phase != 0 && j < 60) begin
            r = (j < 6) ? rdy_hi : ((j < 9) ? 1'b0 : 1'b1);
            step(post_valid ? 1'($urandom_range(1)) : 1'b0, 16'($urandom), 1'b0, r);
            j++;
        end
        check("frame_idle", int'(busy), 0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; arm = 1'b0; rdy = 1'b0; din = '0;
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back frame, data equals index
        step(1'b0, '0, 1'b1, 1'b0);
        fill(100, 1'b1, 1'b0, 1'b0, -1);
        finish_frame(1'b0, 1'b0);

        // stale-high iRDY, 50% valid, arm noise, drops in idle and after fill
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        fill(50, 1'b0, 1'b1, 1'b1, -1);
        finish_frame(1'b1, 1'b1);

        // async reset partway through a frame, then a clean re-arm
        step(1'b0, '0, 1'b1, 1'b0);
        fill(100, 1'b1, 1'b0, 1'b0, 1000);
        check("mid_idx", m_cnt, 1000);
        do_reset("midrst");
        step(1'b0, '0, 1'b1, 1'b0);
        fill(70, 1'b1, 1'b1, 1'b0, -1);
        finish_frame(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
